// File: rtl/vpu_stream_ctrl_if.sv
// ----------------------------------------------------------------------------
// vpu_stream_ctrl_if
// Bundles the unified-buffer and VPU-lane traffic of vpu_stream_ctrl.
//   rd_req_*     : UB row read request (valid/ready) and row address
//   rd_rsp_*     : UB read response, in order, no backpressure
//   vpu_*_in     : row, bias row and pathway mode presented to the VPU
//   vpu_*_out    : VPU result row, all lanes aligned
//   wr_req_*     : UB row write request (valid/ready), address and data
// master = controller side, slave = UB / VPU side.
// Rows are DATA_W*LANES bits wide with lane 0 in the MSB slice.
// ----------------------------------------------------------------------------
interface vpu_stream_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 8,
    parameter int ADDR_W = 10
);
    localparam int ROW_BITS = DATA_W * LANES;

    logic                rd_req_val;
    logic                rd_req_rdy;
    logic [ADDR_W-1:0]   rd_req_addr;
    logic                rd_rsp_val;
    logic [ROW_BITS-1:0] rd_rsp_data;

    logic                vpu_valid_in;
    logic [ROW_BITS-1:0] vpu_data_in;
    logic [ROW_BITS-1:0] vpu_bias_in;
    logic [3:0]          vpu_pathway;
    logic                vpu_valid_out;
    logic [ROW_BITS-1:0] vpu_data_out;

    logic                wr_req_val;
    logic                wr_req_rdy;
    logic [ADDR_W-1:0]   wr_req_addr;
    logic [ROW_BITS-1:0] wr_req_data;

    modport master (
        output rd_req_val, rd_req_addr,
        input  rd_req_rdy, rd_rsp_val, rd_rsp_data,
        output vpu_valid_in, vpu_data_in, vpu_bias_in, vpu_pathway,
        input  vpu_valid_out, vpu_data_out,
        output wr_req_val, wr_req_addr, wr_req_data,
        input  wr_req_rdy
    );

    modport slave (
        input  rd_req_val, rd_req_addr,
        output rd_req_rdy, rd_rsp_val, rd_rsp_data,
        input  vpu_valid_in, vpu_data_in, vpu_bias_in, vpu_pathway,
        output vpu_valid_out, vpu_data_out,
        input  wr_req_val, wr_req_addr, wr_req_data,
        output wr_req_rdy
    );
endinterface

// File: rtl/vpu_stream_ctrl.sv
// ----------------------------------------------------------------------------
// vpu_stream_ctrl
// Streams cfg_rows rows from the unified buffer through a LANES-wide VPU and
// writes the results back row by row. An optional bias row is preloaded
// before streaming. Reads are credit-limited by the result FIFO depth so the
// FIFO can never overflow under a well-behaved VPU.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             job launch pulse (honoured only when idle)
//   cfg_rows          rows in job, sampled on accepted start
//   cfg_zp_base       Z' read base address
//   cfg_b_base        bias row address
//   cfg_z_base        result write base address
//   cfg_bias_en       1 = preload bias row
//   cfg_pathway       VPU mode
//   busy              high whenever a job is active (incl. the done cycle)
//   done              one-cycle pulse on job completion
//   perf_cycles/perf_stall  only when VPU_STREAM_PERF_EN is defined
//   bus               UB / VPU traffic (vpu_stream_ctrl_if.master)
//
// Optional feature macro: VPU_STREAM_PERF_EN (busy-cycle and stall counters).
// ----------------------------------------------------------------------------
module vpu_stream_ctrl #(
    parameter int  DATA_W     = 16,
    parameter int  LANES      = 8,
    parameter int  ADDR_W     = 10,
    parameter int  MAX_ROWS   = 64,
    parameter int  FIFO_DEPTH = 4,
    localparam int ROW_W      = $clog2(MAX_ROWS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [ADDR_W-1:0] cfg_zp_base,
    input  logic [ADDR_W-1:0] cfg_b_base,
    input  logic [ADDR_W-1:0] cfg_z_base,
    input  logic              cfg_bias_en,
    input  logic [3:0]        cfg_pathway,
    output logic              busy,
    output logic              done,
`ifdef VPU_STREAM_PERF_EN
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall,
`endif
    vpu_stream_ctrl_if.master bus
);
    localparam int ROW_BITS = DATA_W * LANES;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, BIAS_REQ, BIAS_WAIT, STREAM, FINISH} state_t;

    state_t              state_reg, state_next;
    logic [ROW_W-1:0]    rows_reg, rd_issued_reg, wr_done_reg;
    logic [ADDR_W-1:0]   zp_base_reg, b_base_reg, z_base_reg;
    logic [CNT_W-1:0]    outstanding_reg, fifo_count_reg;
    logic [PTR_W-1:0]    fifo_wr_ptr_reg, fifo_rd_ptr_reg;
    logic [ROW_BITS-1:0] fifo_mem [FIFO_DEPTH];

    logic start_ok, stream_rd_hs, wr_hs, fifo_push, fwd;

    assign start_ok     = (state_reg == IDLE) && start;
    // Only Z' reads consume a result credit; the bias read does not.
    assign stream_rd_hs = (state_reg == STREAM) && bus.rd_req_val && bus.rd_req_rdy;
    assign wr_hs        = bus.wr_req_val && bus.wr_req_rdy;
    assign fwd          = (state_reg == STREAM) && bus.rd_rsp_val;
    // A push into a full FIFO is accepted only if a pop frees the slot in the
    // same cycle; otherwise the row is dropped.
    assign fifo_push    = (state_reg == STREAM) && bus.vpu_valid_out &&
                          ((fifo_count_reg != CNT_W'(FIFO_DEPTH)) || wr_hs);

    assign bus.wr_req_val  = (fifo_count_reg != '0);
    assign bus.wr_req_addr = z_base_reg + ADDR_W'(wr_done_reg);
    assign bus.wr_req_data = bus.wr_req_val ? fifo_mem[fifo_rd_ptr_reg] : '0;

    always_comb begin
        state_next      = state_reg;
        busy            = (state_reg != IDLE);
        done            = 1'b0;
        bus.rd_req_val  = 1'b0;
        bus.rd_req_addr = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (cfg_rows == '0)
                        state_next = FINISH;
                    else if (cfg_bias_en)
                        state_next = BIAS_REQ;
                    else
                        state_next = STREAM;
                end
            end
            BIAS_REQ: begin
                bus.rd_req_val  = 1'b1;
                bus.rd_req_addr = b_base_reg;
                if (bus.rd_req_rdy)
                    state_next = BIAS_WAIT;
            end
            BIAS_WAIT: begin
                if (bus.rd_rsp_val)
                    state_next = STREAM;
            end
            STREAM: begin
                bus.rd_req_addr = zp_base_reg + ADDR_W'(rd_issued_reg);
                bus.rd_req_val  = (rd_issued_reg < rows_reg) &&
                                  (outstanding_reg < CNT_W'(FIFO_DEPTH));
                if (wr_done_reg == rows_reg)
                    state_next = FINISH;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            rows_reg         <= '0;
            zp_base_reg      <= '0;
            b_base_reg       <= '0;
            z_base_reg       <= '0;
            rd_issued_reg    <= '0;
            wr_done_reg      <= '0;
            outstanding_reg  <= '0;
            fifo_count_reg   <= '0;
            fifo_wr_ptr_reg  <= '0;
            fifo_rd_ptr_reg  <= '0;
            bus.vpu_valid_in <= 1'b0;
            bus.vpu_data_in  <= '0;
            bus.vpu_bias_in  <= '0;
            bus.vpu_pathway  <= '0;
        end else begin
            state_reg <= state_next;

            if (start_ok) begin
                rows_reg        <= cfg_rows;
                zp_base_reg     <= cfg_zp_base;
                b_base_reg      <= cfg_b_base;
                z_base_reg      <= cfg_z_base;
                bus.vpu_pathway <= cfg_pathway;
                rd_issued_reg   <= '0;
                wr_done_reg     <= '0;
                outstanding_reg <= '0;
                if (!cfg_bias_en)
                    bus.vpu_bias_in <= '0;
            end

            if ((state_reg == BIAS_WAIT) && bus.rd_rsp_val)
                bus.vpu_bias_in <= bus.rd_rsp_data;

            if (stream_rd_hs)
                rd_issued_reg <= rd_issued_reg + ROW_W'(1);
            if (wr_hs)
                wr_done_reg <= wr_done_reg + ROW_W'(1);

            if (stream_rd_hs && !wr_hs)
                outstanding_reg <= outstanding_reg + CNT_W'(1);
            else if (!stream_rd_hs && wr_hs)
                outstanding_reg <= outstanding_reg - CNT_W'(1);

            bus.vpu_valid_in <= fwd;
            if (fwd)
                bus.vpu_data_in <= bus.rd_rsp_data;

            if (fifo_push)
                fifo_wr_ptr_reg <= fifo_wr_ptr_reg + PTR_W'(1);
            if (wr_hs)
                fifo_rd_ptr_reg <= fifo_rd_ptr_reg + PTR_W'(1);
            if (fifo_push && !wr_hs)
                fifo_count_reg <= fifo_count_reg + CNT_W'(1);
            else if (!fifo_push && wr_hs)
                fifo_count_reg <= fifo_count_reg - CNT_W'(1);
        end
    end

    // Result storage carries no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (fifo_push)
            fifo_mem[fifo_wr_ptr_reg] <= bus.vpu_data_out;
    end

`ifdef VPU_STREAM_PERF_EN
    logic stall_cond;
    assign stall_cond = (state_reg == STREAM) && (rd_issued_reg < rows_reg) &&
                        ((outstanding_reg == CNT_W'(FIFO_DEPTH)) ||
                         (bus.rd_req_val && !bus.rd_req_rdy));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (start_ok) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && (perf_cycles != '1))
                perf_cycles <= perf_cycles + 32'd1;
            if (stall_cond && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule
